// File: rtl/fix_seqnum_ascii_serializer.sv
// fix_seqnum_ascii_serializer
// Serializes eight captured BCD digits of a FIX sequence number as ASCII
// bytes over a valid/ready handshake, suppressing leading zeros down to
// MIN_DIGITS. Optional framing ('3','4','=' ... SOH) is built only when the
// macro FIX_SEQ_TAG_EN is defined; the default build emits digits only.
module fix_seqnum_ascii_serializer #(
    parameter int MIN_DIGITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] bcd_0,
    input  logic [3:0] bcd_1,
    input  logic [3:0] bcd_2,
    input  logic [3:0] bcd_3,
    input  logic [3:0] bcd_4,
    input  logic [3:0] bcd_5,
    input  logic [3:0] bcd_6,
    input  logic [3:0] bcd_7,
    input  logic       start,
    output logic       busy,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       digit_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TAG    = 2'd1,
        DIGITS = 2'd2,
        TERM   = 2'd3
    } state_t;

    localparam logic [2:0] MIN_IDX = 3'(MIN_DIGITS - 1);

    // Nibble i of the captured digit word.
    function automatic logic [3:0] digit_at(input logic [31:0] d, input logic [2:0] i);
        return d[{i, 2'b00} +: 4];
    endfunction

    // ASCII for one digit; anything above 9 becomes '?'.
    function automatic logic [7:0] to_ascii(input logic [3:0] d);
        return (d > 4'd9) ? 8'h3F : (8'h30 + {4'h0, d});
    endfunction

    // Highest nonzero digit position, never below the minimum width.
    function automatic logic [2:0] start_index(input logic [31:0] d);
        logic [2:0] hi;
        hi = 3'd0;
        for (int i = 0; i < 8; i++) begin
            hi = (d[4*i +: 4] != 4'd0) ? 3'(i) : hi;
        end
        return (hi < MIN_IDX) ? MIN_IDX : hi;
    endfunction

    // True when any nibble is not a decimal digit.
    function automatic logic any_bad(input logic [31:0] d);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bad = bad | (d[4*i +: 4] > 4'd9);
        end
        return bad;
    endfunction

`ifdef FIX_SEQ_TAG_EN
    // Tag prefix bytes "34=" selected by the tag counter.
    function automatic logic [7:0] tag_byte(input logic [1:0] cnt);
        case (cnt)
            2'd0:    return 8'h33;
            2'd1:    return 8'h34;
            default: return 8'h3D;
        endcase
    endfunction

    logic [1:0] tag_cnt, tag_cnt_n;
`endif

    state_t      state, state_n;
    logic [31:0] digits, digits_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  out_data_n;
    logic        out_valid_n, out_last_n, busy_n, digit_err_n;
    logic [31:0] load_digits;
    logic [2:0]  load_idx;
    logic        accept;

    assign load_digits = {bcd_7, bcd_6, bcd_5, bcd_4, bcd_3, bcd_2, bcd_1, bcd_0};
    assign load_idx    = start_index(load_digits);
    assign accept      = out_valid & out_ready;

    // Next-state and next-output decode; the byte on the bus only changes on an accepted transfer.
    always_comb begin
        state_n     = state;
        digits_n    = digits;
        idx_n       = idx;
        out_data_n  = out_data;
        out_valid_n = out_valid;
        out_last_n  = out_last;
        busy_n      = busy;
        digit_err_n = digit_err;
`ifdef FIX_SEQ_TAG_EN
        tag_cnt_n   = tag_cnt;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    digits_n    = load_digits;
                    idx_n       = load_idx;
                    digit_err_n = any_bad(load_digits);
                    busy_n      = 1'b1;
                    out_valid_n = 1'b1;
`ifdef FIX_SEQ_TAG_EN
                    state_n     = TAG;
                    tag_cnt_n   = 2'd0;
                    out_data_n  = tag_byte(2'd0);
                    out_last_n  = 1'b0;
`else
                    state_n     = DIGITS;
                    out_data_n  = to_ascii(digit_at(load_digits, load_idx));
                    out_last_n  = (load_idx == 3'd0);
`endif
                end else begin
                    state_n = IDLE;
                end
            end
`ifdef FIX_SEQ_TAG_EN
            TAG: begin
                if (accept) begin
                    if (tag_cnt == 2'd2) begin
                        state_n    = DIGITS;
                        out_data_n = to_ascii(digit_at(digits, idx));
                        out_last_n = 1'b0;
                    end else begin
                        tag_cnt_n  = tag_cnt + 2'd1;
                        out_data_n = tag_byte(tag_cnt + 2'd1);
                    end
                end else begin
                    state_n = TAG;
                end
            end
`endif
            DIGITS: begin
                if (accept) begin
                    if (idx == 3'd0) begin
`ifdef FIX_SEQ_TAG_EN
                        state_n     = TERM;
                        out_data_n  = 8'h01;
                        out_last_n  = 1'b1;
`else
                        state_n     = IDLE;
                        out_data_n  = 8'h00;
                        out_last_n  = 1'b0;
                        out_valid_n = 1'b0;
                        busy_n      = 1'b0;
`endif
                    end else begin
                        idx_n      = idx - 3'd1;
                        out_data_n = to_ascii(digit_at(digits, idx - 3'd1));
`ifdef FIX_SEQ_TAG_EN
                        out_last_n = 1'b0;
`else
                        out_last_n = (idx == 3'd1);
`endif
                    end
                end else begin
                    state_n = DIGITS;
                end
            end
`ifdef FIX_SEQ_TAG_EN
            TERM: begin
                if (accept) begin
                    state_n     = IDLE;
                    out_data_n  = 8'h00;
                    out_last_n  = 1'b0;
                    out_valid_n = 1'b0;
                    busy_n      = 1'b0;
                end else begin
                    state_n = TERM;
                end
            end
`endif
            default: begin
                state_n     = IDLE;
                out_data_n  = 8'h00;
                out_last_n  = 1'b0;
                out_valid_n = 1'b0;
                busy_n      = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any field in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            digits    <= 32'h0000_0000;
            idx       <= 3'd0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            digit_err <= 1'b0;
`ifdef FIX_SEQ_TAG_EN
            tag_cnt   <= 2'd0;
`endif
        end else begin
            state     <= state_n;
            digits    <= digits_n;
            idx       <= idx_n;
            out_data  <= out_data_n;
            out_valid <= out_valid_n;
            out_last  <= out_last_n;
            busy      <= busy_n;
            digit_err <= digit_err_n;
`ifdef FIX_SEQ_TAG_EN
            tag_cnt   <= tag_cnt_n;
`endif
        end
    end

endmodule

// File: tb/tb_fix_seqnum_ascii_serializer.sv
// Directed bench for fix_seqnum_ascii_serializer. Two instances share the
// stimulus: MIN_DIGITS=1 (dut1) and MIN_DIGITS=3 (dut3). Expected fields
// follow FIX_SEQ_TAG_EN the same way the design does.
module tb_fix_seqnum_ascii_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] bcd;
    logic        start1, start3, out_ready;
    logic        busy1, valid1, last1, err1;
    logic        busy3, valid3, last3, err3;
    logic [7:0]  data1, data3;

    always #5 clk = ~clk;

    fix_seqnum_ascii_serializer #(.MIN_DIGITS(1)) dut1 (
        .clk(clk), .reset(reset),
        .bcd_0(bcd[3:0]), .bcd_1(bcd[7:4]), .bcd_2(bcd[11:8]), .bcd_3(bcd[15:12]),
        .bcd_4(bcd[19:16]), .bcd_5(bcd[23:20]), .bcd_6(bcd[27:24]), .bcd_7(bcd[31:28]),
        .start(start1), .busy(busy1), .out_data(data1), .out_valid(valid1),
        .out_ready(out_ready), .out_last(last1), .digit_err(err1)
    );

    fix_seqnum_ascii_serializer #(.MIN_DIGITS(3)) dut3 (
        .clk(clk), .reset(reset),
        .bcd_0(bcd[3:0]), .bcd_1(bcd[7:4]), .bcd_2(bcd[11:8]), .bcd_3(bcd[15:12]),
        .bcd_4(bcd[19:16]), .bcd_5(bcd[23:20]), .bcd_6(bcd[27:24]), .bcd_7(bcd[31:28]),
        .start(start3), .busy(busy3), .out_data(data3), .out_valid(valid3),
        .out_ready(out_ready), .out_last(last3), .digit_err(err3)
    );

    bit         sel3;
    logic       cur_valid, cur_last, cur_busy;
    logic [7:0] cur_data;
    assign cur_valid = sel3 ? valid3 : valid1;
    assign cur_last  = sel3 ? last3  : last1;
    assign cur_busy  = sel3 ? busy3  : busy1;
    assign cur_data  = sel3 ? data3  : data1;

    int         tests  = 0;
    int         failed = 0;
    logic [7:0] cap_data [0:15];
    bit         cap_last [0:15];
    int         cap_cyc  [0:15];
    int         cap_n;
    bit         got_last;
    logic [7:0] exp_d [0:15];
    int         exp_n;

    task automatic exp_open();
        exp_n = 0;
`ifdef FIX_SEQ_TAG_EN
        exp_d[0] = 8'h33; exp_d[1] = 8'h34; exp_d[2] = 8'h3D; exp_n = 3;
`endif
    endtask

    task automatic exp_push(input logic [7:0] b);
        exp_d[exp_n] = b;
        exp_n++;
    endtask

    task automatic exp_close();
`ifdef FIX_SEQ_TAG_EN
        exp_push(8'h01);
`endif
    endtask

    // Called at a falling edge; returns at the falling edge of T+1.
    task automatic launch(input bit s3, input logic [31:0] v);
        sel3 = s3;
        bcd  = v;
        if (s3) start3 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    // Records accepted bytes until out_last or the cycle budget runs out.
    task automatic capture(input int budget);
        cap_n    = 0;
        got_last = 1'b0;
        for (int c = 0; c < budget && !got_last; c++) begin
            if (cur_valid && out_ready && cap_n < 16) begin
                cap_data[cap_n] = cur_data;
                cap_last[cap_n] = cur_last;
                cap_cyc[cap_n]  = c;
                cap_n++;
                got_last = cur_last;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start1 = 1'b0; start3 = 1'b0; out_ready = 1'b1; bcd = 32'h0; sel3 = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({valid1, busy1, err1, last1, data1} !== 12'h000) begin
            failed++;
            $display("FAIL reset_dut1: got v=%b b=%b e=%b l=%b d=%h, expected all zero", valid1, busy1, err1, last1, data1);
        end
        tests++;
        if ({valid3, busy3, err3, last3, data3} !== 12'h000) begin
            failed++;
            $display("FAIL reset_dut3: got v=%b b=%b e=%b l=%b d=%h, expected all zero", valid3, busy3, err3, last3, data3);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (valid1 !== 1'b0 || busy1 !== 1'b0) begin
            failed++;
            $display("FAIL idle_after_reset: got v=%b b=%b, expected 0 0", valid1, busy1);
        end
    endtask

    task automatic test_value1();
        exp_open(); exp_push(8'h31); exp_close();
        launch(1'b0, 32'h0000_0001);
        capture(40);
        tests++;
        if (!got_last || cap_n !== exp_n) begin
            failed++;
            $display("FAIL value1_len: got %0d bytes (last seen %b), expected %0d", cap_n, got_last, exp_n);
        end
        for (int i = 0; i < exp_n && i < cap_n; i++) begin
            tests++;
            if (cap_data[i] !== exp_d[i] || cap_last[i] !== (i == exp_n - 1) || cap_cyc[i] !== i) begin
                failed++;
                $display("FAIL value1_byte%0d: got %h last=%b cyc=%0d, expected %h last=%b cyc=%0d",
                         i, cap_data[i], cap_last[i], cap_cyc[i], exp_d[i], (i == exp_n - 1), i);
            end
        end
        tests++;
        if (busy1 !== 1'b0 || valid1 !== 1'b0) begin
            failed++;
            $display("FAIL value1_end: got busy=%b valid=%b, expected 0 0", busy1, valid1);
        end
    endtask

    task automatic test_max_value();
        exp_open();
        exp_push(8'h31); exp_push(8'h36); exp_push(8'h37); exp_push(8'h37);
        exp_push(8'h37); exp_push(8'h32); exp_push(8'h31); exp_push(8'h35);
        exp_close();
        launch(1'b0, 32'h1677_7215);
        tests++;
        if (err1 !== 1'b0) begin
            failed++;
            $display("FAIL max_err: got %b, expected 0", err1);
        end
        capture(40);
        tests++;
        if (!got_last || cap_n !== exp_n) begin
            failed++;
            $display("FAIL max_len: got %0d bytes, expected %0d", cap_n, exp_n);
        end
        for (int i = 0; i < exp_n && i < cap_n; i++) begin
            tests++;
            if (cap_data[i] !== exp_d[i] || cap_last[i] !== (i == exp_n - 1) || cap_cyc[i] !== i) begin
                failed++;
                $display("FAIL max_byte%0d: got %h last=%b cyc=%0d, expected %h last=%b cyc=%0d",
                         i, cap_data[i], cap_last[i], cap_cyc[i], exp_d[i], (i == exp_n - 1), i);
            end
        end
    endtask

    task automatic test_min_digits();
        exp_open(); exp_push(8'h30); exp_push(8'h30); exp_push(8'h30); exp_close();
        launch(1'b1, 32'h0000_0000);
        capture(40);
        tests++;
        if (!got_last || cap_n !== exp_n) begin
            failed++;
            $display("FAIL min_zero_len: got %0d bytes, expected %0d", cap_n, exp_n);
        end
        for (int i = 0; i < exp_n && i < cap_n; i++) begin
            tests++;
            if (cap_data[i] !== exp_d[i] || cap_last[i] !== (i == exp_n - 1)) begin
                failed++;
                $display("FAIL min_zero_byte%0d: got %h last=%b, expected %h last=%b",
                         i, cap_data[i], cap_last[i], exp_d[i], (i == exp_n - 1));
            end
        end
        exp_open(); exp_push(8'h30); exp_push(8'h34); exp_push(8'h32); exp_close();
        launch(1'b1, 32'h0000_0042);
        capture(40);
        tests++;
        if (!got_last || cap_n !== exp_n) begin
            failed++;
            $display("FAIL min_42_len: got %0d bytes, expected %0d", cap_n, exp_n);
        end
        for (int i = 0; i < exp_n && i < cap_n; i++) begin
            tests++;
            if (cap_data[i] !== exp_d[i] || cap_last[i] !== (i == exp_n - 1)) begin
                failed++;
                $display("FAIL min_42_byte%0d: got %h last=%b, expected %h last=%b",
                         i, cap_data[i], cap_last[i], exp_d[i], (i == exp_n - 1));
            end
        end
        tests++;
        if (busy3 !== 1'b0) begin
            failed++;
            $display("FAIL min_42_end: got busy=%b, expected 0", busy3);
        end
    endtask

    task automatic test_backpressure();
        bit         pat [0:4];
        logic       prev_valid, prev_ready, prev_last;
        logic [7:0] prev_data;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_open(); exp_push(8'h39); exp_push(8'h30); exp_push(8'h37); exp_close();
        launch(1'b0, 32'h0000_0907);
        cap_n = 0; got_last = 1'b0;
        prev_valid = 1'b0; prev_ready = 1'b1; prev_last = 1'b0; prev_data = 8'h00;
        for (int c = 0; c < 40 && !got_last; c++) begin
            out_ready = (c < 5) ? pat[c] : 1'b1;
            if (c == 1) begin
                start1 = 1'b1;
                bcd    = 32'h9999_9999;
            end else begin
                start1 = 1'b0;
            end
            if (prev_valid && !prev_ready) begin
                tests++;
                if (cur_valid !== 1'b1 || cur_data !== prev_data || cur_last !== prev_last) begin
                    failed++;
                    $display("FAIL bp_hold_c%0d: got v=%b d=%h l=%b, expected v=1 d=%h l=%b",
                             c, cur_valid, cur_data, cur_last, prev_data, prev_last);
                end
            end
            if (cur_valid && out_ready && cap_n < 16) begin
                cap_data[cap_n] = cur_data;
                cap_last[cap_n] = cur_last;
                cap_n++;
                got_last = cur_last;
            end
            prev_valid = cur_valid; prev_ready = out_ready;
            prev_data  = cur_data;  prev_last  = cur_last;
            @(negedge clk);
        end
        out_ready = 1'b1;
        start1    = 1'b0;
        tests++;
        if (!got_last || cap_n !== exp_n) begin
            failed++;
            $display("FAIL bp_len: got %0d bytes, expected %0d", cap_n, exp_n);
        end
        for (int i = 0; i < exp_n && i < cap_n; i++) begin
            tests++;
            if (cap_data[i] !== exp_d[i] || cap_last[i] !== (i == exp_n - 1)) begin
                failed++;
                $display("FAIL bp_byte%0d: got %h last=%b, expected %h last=%b",
                         i, cap_data[i], cap_last[i], exp_d[i], (i == exp_n - 1));
            end
        end
        @(negedge clk);
        tests++;
        if (busy1 !== 1'b0 || valid1 !== 1'b0) begin
            failed++;
            $display("FAIL bp_no_restart: got busy=%b valid=%b, expected 0 0", busy1, valid1);
        end
    endtask

    task automatic test_invalid_digit();
        exp_open(); exp_push(8'h3F); exp_push(8'h33); exp_close();
        launch(1'b0, 32'h0000_00A3);
        tests++;
        if (err1 !== 1'b1) begin
            failed++;
            $display("FAIL bad_err_set: got %b, expected 1", err1);
        end
        capture(40);
        tests++;
        if (!got_last || cap_n !== exp_n) begin
            failed++;
            $display("FAIL bad_len: got %0d bytes, expected %0d", cap_n, exp_n);
        end
        for (int i = 0; i < exp_n && i < cap_n; i++) begin
            tests++;
            if (cap_data[i] !== exp_d[i] || cap_last[i] !== (i == exp_n - 1)) begin
                failed++;
                $display("FAIL bad_byte%0d: got %h last=%b, expected %h last=%b",
                         i, cap_data[i], cap_last[i], exp_d[i], (i == exp_n - 1));
            end
        end
        tests++;
        if (err1 !== 1'b1) begin
            failed++;
            $display("FAIL bad_err_held: got %b, expected 1", err1);
        end
        launch(1'b0, 32'h0000_0005);
        tests++;
        if (err1 !== 1'b0) begin
            failed++;
            $display("FAIL bad_err_clear: got %b, expected 0", err1);
        end
        capture(40);
    endtask

    task automatic test_reset_mid();
        int acc;
        launch(1'b0, 32'h0000_A907);
        acc = 0;
        for (int c = 0; c < 20 && acc < 2; c++) begin
            if (valid1 && out_ready) acc++;
            @(negedge clk);
        end
        tests++;
        if (acc !== 2 || err1 !== 1'b1 || busy1 !== 1'b1) begin
            failed++;
            $display("FAIL rst_mid_pre: got acc=%0d err=%b busy=%b, expected 2 1 1", acc, err1, busy1);
        end
        #1 reset = 1'b1;
        #1;
        tests++;
        if ({valid1, busy1, err1, last1, data1} !== 12'h000) begin
            failed++;
            $display("FAIL rst_mid_async: got v=%b b=%b e=%b l=%b d=%h, expected all zero",
                     valid1, busy1, err1, last1, data1);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        exp_open(); exp_push(8'h35); exp_close();
        launch(1'b0, 32'h0000_0005);
        capture(40);
        tests++;
        if (!got_last || cap_n !== exp_n) begin
            failed++;
            $display("FAIL rst_new_len: got %0d bytes, expected %0d", cap_n, exp_n);
        end
        for (int i = 0; i < exp_n && i < cap_n; i++) begin
            tests++;
            if (cap_data[i] !== exp_d[i] || cap_last[i] !== (i == exp_n - 1) || cap_cyc[i] !== i) begin
                failed++;
                $display("FAIL rst_new_byte%0d: got %h last=%b cyc=%0d, expected %h last=%b cyc=%0d",
                         i, cap_data[i], cap_last[i], cap_cyc[i], exp_d[i], (i == exp_n - 1), i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_value1();
        test_max_value();
        test_min_digits();
        test_backpressure();
        test_invalid_digit();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
